// File: rtl/ctrl_multicycle.sv
// ctrl_multicycle: multi-cycle MIPS control FSM.
// Sequences each instruction through fetch/decode/execute/memory/write-back
// and drives the datapath selects, strobes and the ALU operation code.
//
// Memory handshake: the FSM raises MemRead or MemWrite (with IorD stable)
// and holds in IF, MEM_RD or MEM_WR until MIO_ready=1. The access completes
// in the cycle where strobe and MIO_ready are both 1, and the FSM leaves the
// state on that edge. Every idle-ready cycle adds exactly one cycle.
module ctrl_multicycle (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] OPcode,
   input  logic [5:0] Fun,
   input  logic       zero,
   input  logic       MIO_ready,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ext_zero,
   output logic [2:0] ALU_operation,
   output logic [1:0] PCSource,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       Branch,
   output logic [3:0] state_out
);

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_LW_WB   = 4'd4,
      S_MEM_WR  = 4'd5,
      S_R_EXE   = 4'd6,
      S_R_WB    = 4'd7,
      S_BEQ     = 4'd8,
      S_BNE     = 4'd9,
      S_J       = 4'd10,
      S_JAL     = 4'd11,
      S_JR      = 4'd12,
      S_I_EXE   = 4'd13,
      S_I_WB    = 4'd14
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_XOR = 3'b011;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SRL = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state, state_nx;

   // State register; reset aborts any instruction and restarts at fetch.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IF;
      else     state <= state_nx;
   end

   // Next-state and output decode; reset forces every output to its idle value.
   always_comb begin
      state_nx      = state;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IorD          = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      RegDst        = 2'b00;
      MemtoReg      = 2'b00;
      ALUSrcA       = 2'b00;
      ALUSrcB       = 2'b00;
      ext_zero      = 1'b0;
      ALU_operation = ALU_ADD;
      PCSource      = 2'b00;
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      Branch        = 1'b0;
      state_out     = rst ? 4'd0 : state;

      if (!rst) begin
         case (state)
            S_IF: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = MIO_ready;
               PCWrite = MIO_ready;
               if (MIO_ready) state_nx = S_ID;
            end
            S_ID: begin
               // ALUOut captures PC+4 + (imm<<2) for a possible branch.
               ALUSrcB = 2'b11;
               case (OPcode)
                  OP_LW, OP_SW: state_nx = S_MEM_ADR;
                  OP_RTYPE:     state_nx = (Fun == FN_JR) ? S_JR : S_R_EXE;
                  OP_BEQ:       state_nx = S_BEQ;
                  OP_BNE:       state_nx = S_BNE;
                  OP_J:         state_nx = S_J;
                  OP_JAL:       state_nx = S_JAL;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI:
                                state_nx = S_I_EXE;
                  default:      state_nx = S_IF;
               endcase
            end
            S_MEM_ADR: begin
               ALUSrcA  = 2'b01;
               ALUSrcB  = 2'b10;
               state_nx = (OPcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
               if (MIO_ready) state_nx = S_LW_WB;
            end
            S_LW_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 2'b01;
               state_nx = S_IF;
            end
            S_MEM_WR: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
               if (MIO_ready) state_nx = S_IF;
            end
            S_R_EXE: begin
               ALUSrcA = 2'b01;
               case (Fun)
                  6'b100010: ALU_operation = ALU_SUB;
                  6'b100100: ALU_operation = ALU_AND;
                  6'b100101: ALU_operation = ALU_OR;
                  6'b100110: ALU_operation = ALU_XOR;
                  6'b100111: ALU_operation = ALU_NOR;
                  6'b101010: ALU_operation = ALU_SLT;
                  6'b000010: begin
                     // srl shifts rt by shamt, which rides in the imm field.
                     ALU_operation = ALU_SRL;
                     ALUSrcA       = 2'b10;
                     ALUSrcB       = 2'b10;
                  end
                  default:   ALU_operation = ALU_ADD;
               endcase
               state_nx = S_R_WB;
            end
            S_R_WB: begin
               RegWrite = 1'b1;
               RegDst   = 2'b01;
               state_nx = S_IF;
            end
            S_BEQ, S_BNE: begin
               ALUSrcA       = 2'b01;
               ALU_operation = ALU_SUB;
               PCWriteCond   = 1'b1;
               PCSource      = 2'b01;
               Branch        = (state == S_BEQ);
               state_nx      = S_IF;
            end
            S_J: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               state_nx = S_IF;
            end
            S_JAL: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
               state_nx = S_IF;
            end
            S_JR: begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
               state_nx = S_IF;
            end
            S_I_EXE: begin
               ALUSrcA = 2'b01;
               ALUSrcB = 2'b10;
               case (OPcode)
                  OP_ANDI: begin ALU_operation = ALU_AND; ext_zero = 1'b1; end
                  OP_ORI:  begin ALU_operation = ALU_OR;  ext_zero = 1'b1; end
                  OP_XORI: begin ALU_operation = ALU_XOR; ext_zero = 1'b1; end
                  OP_SLTI: ALU_operation = ALU_SLT;
                  default: ALU_operation = ALU_ADD;
               endcase
               state_nx = S_I_WB;
            end
            S_I_WB: begin
               RegWrite = 1'b1;
               state_nx = S_IF;
            end
            default: state_nx = S_IF;
         endcase
      end
   end

endmodule
